// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with LCD-ready ASCII output.
// Results are registered once per conversion and held frozen until the next one completes.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 16,
  parameter int NUM_DIGITS = 5,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [BIN_WIDTH-1:0]    value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ready_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic [8*NUM_DIGITS-1:0] ascii_o,
  output logic [1:0]              state_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SH_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [SH_W-1:0]         r_shreg;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_done;
  logic                    r_ready;
  logic [BCD_W-1:0]        r_bcd;
  logic [8*NUM_DIGITS-1:0] r_ascii;

  logic [BCD_W-1:0]        w_bcd_field;
  logic [SH_W-1:0]         w_added;
  logic [8*NUM_DIGITS-1:0] w_ascii;

  // Every nibble >= 5 gets +3; the result never exceeds 12, so no carry crosses nibbles.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Leading zeros blank to space while scanning from the MS digit; the units digit always shows.
  function automatic logic [8*NUM_DIGITS-1:0] to_ascii(input logic [BCD_W-1:0] b);
    logic [8*NUM_DIGITS-1:0] a;
    logic                    lead;
    a    = '0;
    lead = BLANK_LZ;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i != 0 && lead && b[4*i +: 4] == 4'd0) begin
        a[8*i +: 8] = 8'h20;
      end else begin
        lead        = 1'b0;
        a[8*i +: 8] = {4'h3, b[4*i +: 4]};
      end
    end
    return a;
  endfunction

  assign w_bcd_field = r_shreg[SH_W-1 -: BCD_W];
  assign w_added     = {add3(w_bcd_field), r_shreg[BIN_WIDTH-1:0]};
  assign w_ascii     = to_ascii(w_bcd_field);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
      r_bcd     <= '0;
      r_ascii   <= to_ascii(BCD_W'(0));
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_shreg   <= {{BCD_W{1'b0}}, value_i};
            r_bit_cnt <= '0;
            r_state   <= S_ADD;
          end
        end
        S_ADD: begin
          r_shreg <= w_added;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_shreg   <= r_shreg << 1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_state   <= (r_bit_cnt == LAST_CNT) ? S_DONE : S_ADD;
        end
        S_DONE: begin
          r_bcd   <= w_bcd_field;
          r_ascii <= w_ascii;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state != S_IDLE);
  assign done_o  = r_done;
  assign ready_o = r_ready;
  assign bcd_o   = r_bcd;
  assign ascii_o = r_ascii;
  assign state_o = r_state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases plus randomized
// back-to-back conversions scored against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] value_i = '0;
  logic        busy_o, done_o, ready_o;
  logic [19:0] bcd_o;
  logic [39:0] ascii_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];

  localparam logic [39:0] ASCII_ZERO = 40'h2020202030;

  bin_to_bcd_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .value_i (value_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .ready_o (ready_o),
    .bcd_o   (bcd_o),
    .ascii_o (ascii_o),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by division, ASCII via right-justified decimal formatting.
  function automatic logic [19:0] model_bcd(input int v);
    logic [19:0] r;
    int          p;
    int          d;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      d = (v / p) % 10;
      r[4*i +: 4] = d[3:0];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [39:0] model_ascii(input int v);
    string       s;
    logic [39:0] a;
    s = $sformatf("%5d", v);
    a = '0;
    for (int i = 0; i < 5; i++) a[8*(4-i) +: 8] = s[i];
    return a;
  endfunction

  task automatic run_conv(input logic [15:0] v, input int glitch_k, input logic [15:0] glitch_v);
    int          k;
    int          busy_cnt;
    int          bcd_changes;
    bit          got;
    logic [19:0] prev_bcd;
    prev_bcd    = bcd_o;
    value_i     = v;
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
    k           = 0;
    busy_cnt    = 0;
    bcd_changes = 0;
    got         = 1'b0;
    while (k < 100) begin
      if (done_o) begin
        got = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      if (bcd_o !== prev_bcd) bcd_changes++;
      if (k == glitch_k) begin
        value_i = glitch_v;
        start_i = 1'b1;
      end
      step();
      start_i = 1'b0;
      k++;
    end
    check("done_seen", 64'(got), 64'(1));
    check("latency", 64'(k), 64'(33));
    check("busy_cycles", 64'(busy_cnt), 64'(33));
    check("hold_during_conv", 64'(bcd_changes), 64'(0));
    check("bcd", 64'(bcd_o), 64'(model_bcd(int'(v))));
    check("ascii", 64'(ascii_o), 64'(model_ascii(int'(v))));
    check("busy_at_done", 64'(busy_o), 64'(0));
    check("ready", 64'(ready_o), 64'(1));
    step();
    check("done_pulse_width", 64'(done_o), 64'(0));
  endtask

  task automatic idle_watch(input int n);
    int dones;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      if (done_o) dones++;
      step();
    end
    check("spurious_done", 64'(dones), 64'(0));
  endtask

  function automatic logic [15:0] next_val(input bit alt, input int idx);
    logic [15:0] r;
    if (alt) r = (idx % 2 == 0) ? 16'd12 : 16'd34;
    else     r = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
    return r;
  endfunction

  task automatic run_stream(input int n, input bit alt);
    int          sent;
    int          done_cnt;
    int          gap;
    int          guard;
    int          changes;
    bit          first;
    logic [15:0] v;
    logic [15:0] e;
    logic [19:0] prev_bcd;
    exp_q.delete();
    v        = next_val(alt, 0);
    value_i  = v;
    exp_q.push_back(v);
    sent     = 1;
    start_i  = 1'b1;
    step();
    done_cnt = 0;
    gap      = 0;
    guard    = 0;
    changes  = 0;
    first    = 1'b1;
    prev_bcd = bcd_o;
    while (done_cnt < n && guard < n * 40 + 100) begin
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("extra_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("stream_bcd", 64'(bcd_o), 64'(model_bcd(int'(e))));
          check("stream_ascii", 64'(ascii_o), 64'(model_ascii(int'(e))));
        end
        if (!first) check("stream_period", 64'(gap), 64'(34));
        check("stream_stable", 64'(changes), 64'(0));
        first    = 1'b0;
        gap      = 0;
        changes  = 0;
        prev_bcd = bcd_o;
        done_cnt++;
        if (sent < n) begin
          v       = next_val(alt, sent);
          value_i = v;
          exp_q.push_back(v);
          sent++;
        end else begin
          start_i = 1'b0;
        end
      end else if (bcd_o !== prev_bcd) begin
        changes++;
      end
      step();
      gap++;
      guard++;
    end
    start_i = 1'b0;
    check("stream_count", 64'(done_cnt), 64'(n));
  endtask

  initial begin
    // reset state
    reset = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_bcd", 64'(bcd_o), 64'(0));
    check("rst_ascii", 64'(ascii_o), 64'(ASCII_ZERO));
    check("rst_state", 64'(state_o), 64'(0));
    reset = 1'b1;
    step();

    // directed values, including add-3 boundaries
    run_conv(16'd0, -1, 16'd0);
    check("zero_ascii", 64'(ascii_o), 64'(ASCII_ZERO));
    run_conv(16'd65535, -1, 16'd0);
    check("max_bcd", 64'(bcd_o), 64'(20'h65535));
    run_conv(16'd100, -1, 16'd0);
    check("ascii_100", 64'(ascii_o), 64'(40'h2020313030));
    run_conv(16'd9, -1, 16'd0);
    run_conv(16'd10, -1, 16'd0);

    // start and value change mid-conversion are ignored
    run_conv(16'd1234, 4, 16'd777);
    check("ignore_mid_start", 64'(bcd_o), 64'(20'h01234));
    idle_watch(40);

    // reset mid-conversion aborts
    value_i = 16'd4321;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    check("abort_done", 64'(done_o), 64'(0));
    check("abort_busy", 64'(busy_o), 64'(0));
    check("abort_bcd", 64'(bcd_o), 64'(0));
    check("abort_ready", 64'(ready_o), 64'(0));
    check("abort_ascii", 64'(ascii_o), 64'(ASCII_ZERO));
    step();
    reset = 1'b1;
    idle_watch(40);
    check("abort_ready_held", 64'(ready_o), 64'(0));
    run_conv(16'd5678, -1, 16'd0);

    // back-to-back with start held high
    run_stream(6, 1'b1);
    idle_watch(40);
    run_stream(1000, 1'b0);
    idle_watch(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
